// File: rtl/reg_bank_if.sv
// Decode/write-back side bundle for reg_bank: read ports, write-back port,
// issue request and the resulting stall / pending-write count.
interface reg_bank_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 6,
  parameter int ADDR_W   = $clog2(NUM_REGS)
);
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic              regWrite;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic              issueValid;
  logic              issueWritesReg;
  logic [ADDR_W-1:0] issueDest;
  logic              issueUses2;
  logic              stall;
  logic [CNT_W-1:0]  busyCount;

  modport master (
    output readReg1, readReg2, regWrite, writeReg, writeData,
           issueValid, issueWritesReg, issueDest, issueUses2,
    input  readData1, readData2, stall, busyCount
  );

  modport slave (
    input  readReg1, readReg2, regWrite, writeReg, writeData,
           issueValid, issueWritesReg, issueDest, issueUses2,
    output readData1, readData2, stall, busyCount
  );
endinterface

// File: rtl/reg_bank.sv
// Architectural register file with pending-write scoreboard and decode stall.
// Optional macro REGBANK_BYPASS_EN enables write-through forwarding on both read ports.
module reg_bank #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 6,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic       clk,
  input  logic       rst_n,
  reg_bank_if.slave  bus
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;

  logic                wr_en_s;
  logic                issue_set_s;
  logic [NUM_REGS-1:0] wr_vec_s;
  logic [NUM_REGS-1:0] set_vec_s;
  logic                bypass1_s;
  logic                bypass2_s;
  logic                haz1_s;
  logic                haz2_s;
  logic                stall_s;
  logic [DATA_W-1:0]   rd1_s;
  logic [DATA_W-1:0]   rd2_s;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [CNT_W-1:0] sum;
    sum = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      sum = sum + CNT_W'(v[i]);
    end
    return sum;
  endfunction

  assign wr_en_s = bus.regWrite && (bus.writeReg != {ADDR_W{1'b0}});

`ifdef REGBANK_BYPASS_EN
  assign bypass1_s = wr_en_s && (bus.writeReg == bus.readReg1);
  assign bypass2_s = wr_en_s && (bus.writeReg == bus.readReg2);
`else
  assign bypass1_s = 1'b0;
  assign bypass2_s = 1'b0;
`endif

  // Read port data: forwarded write data, hard-wired zero for r0, else stored value.
  always_comb begin
    rd1_s = {DATA_W{1'b0}};
    rd2_s = {DATA_W{1'b0}};
    if (bypass1_s) begin
      rd1_s = bus.writeData;
    end else if (bus.readReg1 == {ADDR_W{1'b0}}) begin
      rd1_s = {DATA_W{1'b0}};
    end else begin
      rd1_s = regs_q[bus.readReg1];
    end
    if (bypass2_s) begin
      rd2_s = bus.writeData;
    end else if (bus.readReg2 == {ADDR_W{1'b0}}) begin
      rd2_s = {DATA_W{1'b0}};
    end else begin
      rd2_s = regs_q[bus.readReg2];
    end
  end

  // Hazard detection and the issue-accept decision.
  always_comb begin
    haz1_s = (bus.readReg1 != {ADDR_W{1'b0}}) && busy_q[bus.readReg1] && !bypass1_s;
    haz2_s = bus.issueUses2 && (bus.readReg2 != {ADDR_W{1'b0}}) &&
             busy_q[bus.readReg2] && !bypass2_s;
    stall_s = bus.issueValid && (haz1_s || haz2_s);
    issue_set_s = bus.issueValid && !stall_s && bus.issueWritesReg &&
                  (bus.issueDest != {ADDR_W{1'b0}});
  end

  // One-hot decode of the write-back target and the newly issued destination.
  always_comb begin
    wr_vec_s  = {NUM_REGS{1'b0}};
    set_vec_s = {NUM_REGS{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      wr_vec_s[i]  = wr_en_s && (bus.writeReg == ADDR_W'(i));
      set_vec_s[i] = issue_set_s && (bus.issueDest == ADDR_W'(i));
    end
  end

  // Busy next state: a newer producer issuing on the write-back edge keeps the bit set.
  always_comb begin
    busy_d = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == 0) begin
        busy_d[i] = 1'b0;
      end else if (set_vec_s[i]) begin
        busy_d[i] = 1'b1;
      end else if (wr_vec_s[i]) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
    count_d = popcount(busy_d);
  end

  // Scoreboard state and its registered population count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= {NUM_REGS{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Register storage; entry 0 is never written and stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_vec_s[i]) begin
          regs_q[i] <= bus.writeData;
        end
      end
    end
  end

  assign bus.readData1 = rd1_s;
  assign bus.readData2 = rd2_s;
  assign bus.stall     = stall_s;
  assign bus.busyCount = count_q;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: the driver queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_reg_bank;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 6;

  localparam logic [3:0] M_RD1 = 4'b0001;
  localparam logic [3:0] M_RD2 = 4'b0010;
  localparam logic [3:0] M_STL = 4'b0100;
  localparam logic [3:0] M_CNT = 4'b1000;
  localparam logic [3:0] M_ALL = 4'b1111;

`ifdef REGBANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string             name;
    logic [3:0]        mask;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              stl;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   n_total;
  int   n_pass;

  reg_bank_if bus ();

  reg_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    n_total++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
    end
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.mask[0]) cmp({e.name, ".rd1"}, bus.readData1, e.rd1);
      if (e.mask[1]) cmp({e.name, ".rd2"}, bus.readData2, e.rd2);
      if (e.mask[2]) cmp({e.name, ".stall"}, DATA_W'(bus.stall), DATA_W'(e.stl));
      if (e.mask[3]) cmp({e.name, ".cnt"}, DATA_W'(bus.busyCount), DATA_W'(e.cnt));
    end
  end

  task automatic expect_out(input string nm, input logic [3:0] m, input logic [DATA_W-1:0] r1,
                            input logic [DATA_W-1:0] r2, input logic s, input logic [CNT_W-1:0] c);
    exp_t e;
    e.name = nm; e.mask = m; e.rd1 = r1; e.rd2 = r2; e.stl = s; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.regWrite       = 1'b0;
    bus.writeReg       = '0;
    bus.writeData      = '0;
    bus.issueValid     = 1'b0;
    bus.issueWritesReg = 1'b0;
    bus.issueDest      = '0;
    bus.issueUses2     = 1'b0;
    bus.readReg1       = '0;
    bus.readReg2       = '0;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] dest, input logic wr);
    bus.issueValid     = 1'b1;
    bus.issueWritesReg = wr;
    bus.issueDest      = dest;
  endtask

  task automatic wb(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    bus.regWrite  = 1'b1;
    bus.writeReg  = r;
    bus.writeData = d;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    idle();
    repeat (2) step();

    // Reset state
    rst_n = 1'b1;
    bus.readReg1 = 5'd1; bus.readReg2 = 5'd31; bus.issueValid = 1'b1;
    expect_out("reset", M_ALL, 32'h0, 32'h0, 1'b0, 6'd0);

    // Write r5 and observe same-cycle read
    step(); idle();
    wb(5'd5, 32'hDEADBEEF); bus.readReg1 = 5'd5;
    expect_out("wr_same_cycle", M_RD1, BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 1'b0, 6'd0);
    step(); idle();
    wb(5'd0, 32'h12345678); bus.readReg1 = 5'd5; bus.readReg2 = 5'd0;
    expect_out("wr_r0_cycle", M_RD1 | M_RD2, 32'hDEADBEEF, 32'h0, 1'b0, 6'd0);
    step(); idle();
    bus.readReg1 = 5'd5; bus.readReg2 = 5'd0;
    expect_out("rd_r5_r0", M_ALL, 32'hDEADBEEF, 32'h0, 1'b0, 6'd0);

    // RAW hazard on r7
    step(); idle();
    issue(5'd7, 1'b1);
    expect_out("issue7", M_STL | M_CNT, 32'h0, 32'h0, 1'b0, 6'd0);
    step(); idle();
    issue(5'd0, 1'b0); bus.readReg1 = 5'd7;
    expect_out("raw7", M_STL | M_CNT, 32'h0, 32'h0, 1'b1, 6'd1);
    step();
    wb(5'd7, 32'h0000002A);
    expect_out("raw7_wb", M_ALL, BYP ? 32'h2A : 32'h0, 32'h0, BYP ? 1'b0 : 1'b1, 6'd1);
    step();
    bus.regWrite = 1'b0;
    expect_out("raw7_after", M_ALL, 32'h2A, 32'h0, 1'b0, 6'd0);

    // Set and clear of r9 on the same edge
    step(); idle();
    issue(5'd9, 1'b1);
    expect_out("issue9", M_STL | M_CNT, 32'h0, 32'h0, 1'b0, 6'd0);
    step();
    wb(5'd9, 32'h99);
    expect_out("waw9_wb", M_STL | M_CNT, 32'h0, 32'h0, 1'b0, 6'd1);
    step(); idle();
    issue(5'd0, 1'b0); bus.readReg1 = 5'd9;
    expect_out("busy9_kept", M_ALL, 32'h99, 32'h0, 1'b1, 6'd1);
    step(); idle();
    wb(5'd9, 32'h77);
    expect_out("clear9", M_STL | M_CNT, 32'h0, 32'h0, 1'b0, 6'd1);
    step(); idle();
    bus.readReg1 = 5'd9;
    expect_out("cleared9", M_RD1 | M_CNT, 32'h77, 32'h0, 1'b0, 6'd0);

    // Port 2 hazard gated by issueUses2
    step(); idle();
    issue(5'd3, 1'b1);
    step(); idle();
    issue(5'd0, 1'b0); bus.readReg2 = 5'd3; bus.issueUses2 = 1'b0;
    expect_out("uses2_off", M_STL | M_CNT, 32'h0, 32'h0, 1'b0, 6'd1);
    step();
    bus.issueUses2 = 1'b1;
    expect_out("uses2_on", M_STL | M_CNT, 32'h0, 32'h0, 1'b1, 6'd1);
    step(); idle();
    wb(5'd3, 32'h3);

    // Fill every destination, then drain
    for (int d = 1; d < 32; d++) begin
      step(); idle();
      issue(ADDR_W'(d), 1'b1);
      expect_out($sformatf("fill%0d", d), M_STL | M_CNT, 32'h0, 32'h0, 1'b0, CNT_W'(d - 1));
    end
    step(); idle();
    issue(5'd0, 1'b1);
    expect_out("full", M_CNT, 32'h0, 32'h0, 1'b0, 6'd31);
    step(); idle();
    bus.readReg1 = 5'd0; issue(5'd0, 1'b0);
    expect_out("full_r0", M_STL | M_CNT, 32'h0, 32'h0, 1'b0, 6'd31);
    for (int d = 1; d < 32; d++) begin
      step(); idle();
      wb(ADDR_W'(d), DATA_W'(d));
      expect_out($sformatf("drain%0d", d), M_CNT, 32'h0, 32'h0, 1'b0, CNT_W'(32 - d));
    end
    step(); idle();
    bus.readReg1 = 5'd17; bus.readReg2 = 5'd31;
    expect_out("drained", M_ALL, 32'd17, 32'd31, 1'b0, 6'd0);

    // Asynchronous reset with busy bits pending
    step(); idle();
    issue(5'd1, 1'b1);
    step(); idle();
    issue(5'd2, 1'b1);
    step(); idle();
    bus.readReg1 = 5'd5;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", M_RD1 | M_CNT, 32'h0, 32'h0, 1'b0, 6'd0);
    step();
    rst_n = 1'b1;
    wb(5'd4, 32'h44); bus.readReg1 = 5'd2; issue(5'd0, 1'b0);
    expect_out("post_rst_wb", M_STL | M_CNT, 32'h0, 32'h0, 1'b0, 6'd0);
    step(); idle();
    bus.readReg1 = 5'd4;
    expect_out("post_rst_rd", M_RD1 | M_CNT, 32'h44, 32'h0, 1'b0, 6'd0);

    begin
      int budget;
      budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
        step();
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_total++;
        $display("FAIL drain_queue: %0d expectations left, expected 0", exp_q.size());
      end
    end
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Architectural register file plus pending-write scoreboard, directly downstream of the write-back data-select stage.
- Stores the 32-bit result selected from ALU result, load data or next-PC into the register named by the write address.
- Serves two asynchronous read ports to decode.
- Tracks which registers have an in-flight producer and raises a stall when decode would read one.

Parameters:
DATA_W, 32, register data width
NUM_REGS, 32, number of registers; address width ADDR_W = clog2(NUM_REGS) = 5
CNT_W, 6, width of busyCount; must hold NUM_REGS

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
readReg1  input  ADDR_W  read port 1 address (rs)
readReg2  input  ADDR_W  read port 2 address (rt)
readData1  output  DATA_W  read port 1 data
readData2  output  DATA_W  read port 2 data
regWrite  input  1  write-back enable
writeReg  input  ADDR_W  write-back destination
writeData  input  DATA_W  write-back data (select-mux output)
issueValid  input  1  decode presents an instruction this cycle
issueWritesReg  input  1  issuing instruction will write a register
issueDest  input  ADDR_W  destination of issuing instruction
issueUses2  input  1  instruction reads readReg2 (0 = rt is a destination or unused)
stall  output  1  decode must hold; issue not accepted
busyCount  output  CNT_W  number of registers with a pending write

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (rst_n=0, asynchronous):
  - all registers clear to 0
  - all busy bits clear to 0
  - busyCount=0
  - readData1/2 therefore read 0 and stall=0
  - release is synchronous to the next clk edge.
- Register 0:
  - always reads 0
  - writes to it are discarded
  - it is never marked busy and never causes a stall.
- Write:
  - on a rising edge with regWrite=1 and writeReg!=0, the register takes writeData.
  - Latency: 1 cycle; a same-cycle read returns the old value unless REGBANK_BYPASS_EN is defined.
- Reads are combinational from readReg1/readReg2 with no clock latency.
- Scoreboard:
  - one busy bit per register.
  - Set on an edge when issueValid=1, stall=0, issueWritesReg=1 and issueDest!=0.
  - Cleared on an edge when regWrite=1 and writeReg!=0.
  - Set and clear of the same register on the same edge: set wins (a newer producer has issued).
  - Clearing a register whose busy bit is already 0 is harmless; no error is raised.
- Hazard term: hazX = (readRegX!=0) && busy[readRegX] && !bypassX.
  - bypassX=0 when the feature is off.
  - hazard on port 2 counts only when issueUses2=1.
- stall = issueValid && (haz1 || haz2). It is combinational and requires no issue to be accepted while it is high.
- WAW: an issue whose issueDest is already busy is accepted; the busy bit stays 1.
- busyCount:
  - registered popcount of busy, updated on the same edge as busy.
  - saturates by construction at NUM_REGS-1, since register 0 is never busy.
- Reset asserted mid-operation:
  - all pending state is dropped immediately.
  - a write-back arriving in the first cycle after release is performed; its clear of an already-zero busy bit is a no-op.

Optional Feature:
- Macro REGBANK_BYPASS_EN.
- Defined:
  - write-through forwarding: when regWrite=1, writeReg!=0 and writeReg==readRegX, readDataX=writeData in the same cycle.
  - bypassX=1 in that case, so a register being written this cycle does not stall even though its busy bit is still 1.
- Undefined:
  - reads return only stored values.
  - a busy register stalls until the cycle after its write-back edge; stall then drops.

Test Plan:
- Reset, then read r1 and r31 -> readData1=0, readData2=0, stall=0, busyCount=0. Assert rst_n=0 mid-run after busy bits are set -> busyCount=0 immediately.
- Write r5=0xDEADBEEF and r0=0x12345678, then read r5 and r0 next cycle -> 0xDEADBEEF and 0x00000000.
- Issue with issueDest=7, then issue with readReg1=7 -> stall=1 and busyCount=1. Write back r7=0x0000002A:
  - bypass off: stall=1 that cycle, 0 the next cycle, read 0x2A.
  - bypass on: stall=0 and readData1=0x2A in the write-back cycle.
- Same edge: issue dest=9 and write back writeReg=9 -> busy[9] stays 1, busyCount unchanged.
- issueUses2=0 with readReg2 busy -> stall=0. Set issueUses2=1 -> stall=1.
- Issue 31 distinct destinations r1..r31 with no write-back -> busyCount=31. Then 31 write-backs -> busyCount=0.
